// File: rtl/bf0_out_merge.sv
// Stage-0 butterfly output merge: forwards add results live, buffers sub results
// and replays them afterwards. Optional dout_idx port enabled by BF0_OUT_IDX_EN.
module bf0_out_merge #(
  parameter int DATA_W    = 10,
  parameter int UNIT_SIZE = 16,
  parameter int CLK_CNT   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] din_add_r [UNIT_SIZE],
  input  logic signed [DATA_W-1:0] din_add_i [UNIT_SIZE],
  input  logic signed [DATA_W-1:0] din_sub_r [UNIT_SIZE],
  input  logic signed [DATA_W-1:0] din_sub_i [UNIT_SIZE],
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] dout_r [UNIT_SIZE],
  output logic signed [DATA_W-1:0] dout_i [UNIT_SIZE],
`ifdef BF0_OUT_IDX_EN
  output logic [$clog2(2*CLK_CNT)-1:0] dout_idx,
`endif
  output logic                     err_overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CNT_W = (CLK_CNT > 1) ? $clog2(CLK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_CNT - 1);

`ifdef BF0_OUT_IDX_EN
  localparam int IDX_W = $clog2(2*CLK_CNT);
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_beat;

  logic signed [DATA_W-1:0] sub_buf_r [CLK_CNT][UNIT_SIZE];
  logic signed [DATA_W-1:0] sub_buf_i [CLK_CNT][UNIT_SIZE];

  // IDLE and PASS accept beats identically; IDLE simply has cnt at 0.
  assign accept    = valid_in && (state != ST_DRAIN);
  assign last_beat = (cnt == CNT_LAST);

  // NOTE: the sub buffer is plain storage with no reset so it maps onto RAM;
  // every entry is written before it is read within a frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      sub_buf_r[cnt] <= din_sub_r;
      sub_buf_i[cnt] <= din_sub_i;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      valid_out   <= 1'b0;
      dout_r      <= '{default: '0};
      dout_i      <= '{default: '0};
      err_overrun <= 1'b0;
`ifdef BF0_OUT_IDX_EN
      dout_idx    <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_IDLE, ST_PASS: begin
          if (valid_in) begin
            valid_out <= 1'b1;
            dout_r    <= din_add_r;
            dout_i    <= din_add_i;
`ifdef BF0_OUT_IDX_EN
            dout_idx  <= IDX_W'(cnt);
`endif
            if (last_beat) begin
              cnt   <= '0;
              state <= ST_DRAIN;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ST_PASS;
            end
          end
        end
        ST_DRAIN: begin
          valid_out <= 1'b1;
          dout_r    <= sub_buf_r[cnt];
          dout_i    <= sub_buf_i[cnt];
`ifdef BF0_OUT_IDX_EN
          dout_idx  <= IDX_W'(CLK_CNT) + IDX_W'(cnt);
`endif
          // A beat arriving mid-drain has nowhere to go; it is dropped and flagged.
          if (valid_in) err_overrun <= 1'b1;
          if (last_beat) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/bf0_out_merge.md
Name: bf0_out_merge

Overview:
- Output-side partner of the stage-0 butterfly, on the butterfly's result interface.
- The butterfly presents add and sub results together for CLK_CNT consecutive valid beats. This block merges them back into a single 16-lane stream for the next FFT stage.
- During the window it forwards add results and stores sub results in an internal buffer. It then replays the sub results for CLK_CNT cycles, restoring the sample order (first half, then second half).

Parameters:
- DATA_W, 10, bit width of each real/imag sample (signed).
- UNIT_SIZE, 16, parallel lanes per beat.
- CLK_CNT, 16, beats per butterfly window; also the buffer depth in beats.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- valid_in  input  1  butterfly result valid.
- din_add_r  input  signed [DATA_W-1:0] x UNIT_SIZE  butterfly add result, real.
- din_add_i  input  signed [DATA_W-1:0] x UNIT_SIZE  butterfly add result, imag.
- din_sub_r  input  signed [DATA_W-1:0] x UNIT_SIZE  butterfly sub result, real.
- din_sub_i  input  signed [DATA_W-1:0] x UNIT_SIZE  butterfly sub result, imag.
- valid_out  output  1  merged stream valid.
- dout_r  output  signed [DATA_W-1:0] x UNIT_SIZE  merged output, real.
- dout_i  output  signed [DATA_W-1:0] x UNIT_SIZE  merged output, imag.
- err_overrun  output  1  sticky: valid_in seen while draining.

Behaviour:
- Single clock domain. Asynchronous active-low reset.
- Reset state:
  - FSM = IDLE; beat counter = 0.
  - valid_out = 0; dout_r/dout_i all lanes = 0; err_overrun = 0.
  - Buffer contents need not be reset.
- All outputs are registered. Latency from an accepted input beat to its add output is 1 cycle.
- FSM states:
  - IDLE:
    - valid_in=1: forward add, write sub to buf[0], cnt=1, go to PASS.
    - Otherwise valid_out=0 next cycle.
  - PASS:
    - Each cycle with valid_in=1: dout <= din_add, buf[cnt] <= din_sub, valid_out <= 1, cnt++.
    - valid_in=0 (gap): valid_out <= 0 next cycle, cnt holds, state holds.
    - On the CLK_CNT-th beat: cnt=0, go to DRAIN.
  - DRAIN:
    - Each cycle: dout <= buf[cnt], valid_out <= 1, cnt++.
    - Exactly CLK_CNT cycles, no stalls.
    - After buf[CLK_CNT-1] is read: cnt=0, go to IDLE.
- Throughput: a window every 2*CLK_CNT cycles (16 valid, 16 idle) gives a gap-free valid_out stream. The first output of a new window directly follows the last drain output.
- Overrun: valid_in=1 while in DRAIN (including the last DRAIN cycle):
  - The beat is dropped and err_overrun sets, sticky until reset.
  - The drain sequence continues unaffected.
- Width rule: pure pass-through, no arithmetic, no truncation. Lane j of the input maps to lane j of the output.
- Reset mid-operation: returns to IDLE immediately. A partially filled or draining frame is discarded; no output after rstn deasserts until a new valid_in.
- Frame output order: add beat 0..CLK_CNT-1, then sub beat 0..CLK_CNT-1.

Optional Feature:
- Macro BF0_OUT_IDX_EN.
- Defined:
  - Adds output port dout_idx, width $clog2(2*CLK_CNT), registered, reset 0.
  - Carries the position of the current beat within the frame: add beats 0..CLK_CNT-1, sub beats CLK_CNT..2*CLK_CNT-1.
  - Meaningful only when valid_out=1; holds its last value otherwise.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- Single window:
  - Stimulus: 16 contiguous beats, add lane j = beat*16+j, sub lane j = -(beat*16+j).
  - Required: valid_out high for 32 contiguous cycles starting 1 cycle after the first valid_in. Outputs 0..255 in order, then 0, -1 .. -255. err_overrun=0.
- Back-to-back frames:
  - Stimulus: windows at cycles 0 and 32.
  - Required: valid_out continuous for 64 cycles; second frame data is correct.
- Gaps:
  - Stimulus: valid_in pattern 1,0,1,0,... for 16 beats.
  - Required: add outputs appear 1 cycle after each beat with valid_out=0 in the gaps. Drain starts after the 16th beat, 16 contiguous cycles.
- Overrun:
  - Stimulus: valid_in=1 at drain cycle 5.
  - Required: err_overrun=1 from the next cycle and stays high. Drain data is unchanged. The dropped beat never appears on dout.
- Reset mid-drain:
  - Stimulus: rstn low at drain cycle 8.
  - Required: valid_out, dout and err_overrun go to 0 immediately. No output until the next window, which is output correctly.
- BF0_OUT_IDX_EN:
  - Stimulus: single window.
  - Required: dout_idx counts 0..31 alongside valid_out.
